// File: rtl/dump_pkg.sv
// Shared definitions for the matrix result dumper: default widths, the
// dumper state encoding and the word-count helper.
// Optional feature macro: DUMP_CHECKSUM_EN adds the CSUM state.
package dump_pkg;

   localparam int unsigned ADDR_WIDTH_DEF = 16;
   localparam int unsigned DATA_WIDTH_DEF = 16;
   localparam int unsigned DIM_WIDTH      = 8;
   localparam int unsigned CNT_WIDTH      = 16;
   localparam int unsigned BYTE_WIDTH     = 8;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_WAIT = 3'd2,
      ST_HI   = 3'd3,
      ST_LO   = 3'd4,
`ifdef DUMP_CHECKSUM_EN
      ST_CSUM = 3'd5,
`endif
      ST_DONE = 3'd6
   } state_e;

   // Number of RAM words in a rows x cols matrix (16-bit product).
   function automatic logic [CNT_WIDTH-1:0] word_count(input logic [DIM_WIDTH-1:0] rows,
                                                      input logic [DIM_WIDTH-1:0] cols);
      return CNT_WIDTH'(rows) * CNT_WIDTH'(cols);
   endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector.
// Ports: clk, rst (async active-high), d (level in), rise (one-cycle registered pulse).
// A rise is only reported after d has been seen low since reset, so a level
// already high when reset releases never counts as an edge.
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic d_q, d_d;
   logic armed_q, armed_d;
   logic rise_q, rise_d;

   // Edge evaluation against the registered copy of d
   always_comb begin
      d_d     = d;
      armed_d = armed_q | ~d;
      rise_d  = d & ~d_q & armed_q;
   end

   // Edge register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_q     <= 1'b0;
         armed_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         d_q     <= d_d;
         armed_q <= armed_d;
         rise_q  <= rise_d;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/matrix_result_dumper.sv
// Streams a result matrix from data RAM to the host link as bytes (MSB first)
// when PROCESS_DONE rises.
// Ports: MAIN_CLOCK/RESET (async active-high); PROCESS_DONE start level;
// BASE_ADDR/ROWS/COLS matrix location; ADDR_RAM/DATA_IN_RAM synchronous RAM
// read port (data one cycle after address); BYTE_OUT/BYTE_VALID/BYTE_READY
// byte stream; DUMP_BUSY/DUMP_DONE status.
// Optional feature macro: DUMP_CHECKSUM_EN appends an XOR checksum byte.
module matrix_result_dumper
   import dump_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  MAIN_CLOCK,
   input  logic                  RESET,
   input  logic                  PROCESS_DONE,
   input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
   input  logic [DIM_WIDTH-1:0]  ROWS,
   input  logic [DIM_WIDTH-1:0]  COLS,
   output logic [ADDR_WIDTH-1:0] ADDR_RAM,
   input  logic [DATA_WIDTH-1:0] DATA_IN_RAM,
   output logic [BYTE_WIDTH-1:0] BYTE_OUT,
   output logic                  BYTE_VALID,
   input  logic                  BYTE_READY,
   output logic                  DUMP_BUSY,
   output logic                  DUMP_DONE
);

`ifdef DUMP_CHECKSUM_EN
   localparam state_e ST_TAIL = ST_CSUM;
`else
   localparam state_e ST_TAIL = ST_DONE;
`endif

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic [CNT_WIDTH-1:0]    count_q, count_d;
   logic [CNT_WIDTH-1:0]    idx_q, idx_d;
   logic [DATA_WIDTH-1:0]   word_q, word_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [BYTE_WIDTH-1:0]   byte_q, byte_d;
   logic                    valid_q, valid_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
`ifdef DUMP_CHECKSUM_EN
   logic [BYTE_WIDTH-1:0]   csum_q, csum_d;
`endif

   logic                    start;
   logic                    hs;
   logic [CNT_WIDTH-1:0]    idx_inc;
   logic [CNT_WIDTH-1:0]    start_count;

   rise_detect u_rise (
      .clk  (MAIN_CLOCK),
      .rst  (RESET),
      .d    (PROCESS_DONE),
      .rise (start)
   );

   // Next state; registered outputs are derived from the next state so they
   // line up with the state they describe
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      count_d = count_q;
      idx_d   = idx_q;
      word_d  = word_q;
`ifdef DUMP_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      hs          = valid_q & BYTE_READY;
      idx_inc     = idx_q + CNT_WIDTH'(1);
      start_count = word_count(ROWS, COLS);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d  = BASE_ADDR;
               count_d = start_count;
               idx_d   = '0;
`ifdef DUMP_CHECKSUM_EN
               csum_d  = '0;
`endif
               state_d = (start_count == '0) ? ST_TAIL : ST_ADDR;
            end
         end
         ST_ADDR: state_d = ST_WAIT;
         ST_WAIT: begin
            word_d  = DATA_IN_RAM;
            state_d = ST_HI;
         end
         ST_HI: begin
            if (hs) begin
`ifdef DUMP_CHECKSUM_EN
               csum_d  = csum_q ^ word_q[15:8];
`endif
               state_d = ST_LO;
            end
         end
         ST_LO: begin
            if (hs) begin
`ifdef DUMP_CHECKSUM_EN
               csum_d  = csum_q ^ word_q[7:0];
`endif
               idx_d   = idx_inc;
               state_d = (idx_inc < count_q) ? ST_ADDR : ST_TAIL;
            end
         end
`ifdef DUMP_CHECKSUM_EN
         ST_CSUM: begin
            if (hs) state_d = ST_DONE;
         end
`endif
         ST_DONE: begin
            if (!PROCESS_DONE) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Address wraps modulo 2^ADDR_WIDTH by truncation of the sum
      addr_d = addr_q;
      if (state_d == ST_ADDR) addr_d = base_d + ADDR_WIDTH'(idx_d);

      byte_d  = byte_q;
      valid_d = 1'b0;
      case (state_d)
         ST_HI: begin
            byte_d  = word_d[15:8];
            valid_d = 1'b1;
         end
         ST_LO: begin
            byte_d  = word_d[7:0];
            valid_d = 1'b1;
         end
`ifdef DUMP_CHECKSUM_EN
         ST_CSUM: begin
            byte_d  = csum_d;
            valid_d = 1'b1;
         end
`endif
         default: ;
      endcase

      busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_d = (state_d == ST_DONE);
   end

   // State and output registers
   always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
         count_q <= '0;
         idx_q   <= '0;
         word_q  <= '0;
         addr_q  <= '0;
         byte_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         addr_q  <= addr_d;
         byte_q  <= byte_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef DUMP_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign ADDR_RAM   = addr_q;
   assign BYTE_OUT   = byte_q;
   assign BYTE_VALID = valid_q;
   assign DUMP_BUSY  = busy_q;
   assign DUMP_DONE  = done_q;

endmodule

// File: tb/tb_matrix_result_dumper.sv
// Scoreboard bench for matrix_result_dumper: stimulus pushes expected bytes,
// a monitor pops and compares on every byte handshake.
module tb_matrix_result_dumper;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pd = 1'b0;
   logic [15:0] base = '0;
   logic [7:0]  rows = '0;
   logic [7:0]  cols = '0;
   logic [15:0] addr;
   logic [15:0] din = '0;
   logic [7:0]  bout;
   logic        bvalid;
   logic        bready = 1'b1;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   logic [15:0] mem [0:65535];
   always @(posedge clk) din <= mem[addr];

   matrix_result_dumper dut (
      .MAIN_CLOCK   (clk),
      .RESET        (rst),
      .PROCESS_DONE (pd),
      .BASE_ADDR    (base),
      .ROWS         (rows),
      .COLS         (cols),
      .ADDR_RAM     (addr),
      .DATA_IN_RAM  (din),
      .BYTE_OUT     (bout),
      .BYTE_VALID   (bvalid),
      .BYTE_READY   (bready),
      .DUMP_BUSY    (busy),
      .DUMP_DONE    (done)
   );

   int errors = 0;
   int checks = 0;
   logic [7:0]  exp_q [$];
   logic [15:0] exp_addr [$];
   logic [15:0] addr_log [$];
   int          bytes_seen = 0;
   int          exp_bytes = 0;
   int          ready_mode = 0;
   int          rd_idx = 0;
   int          stall_cnt = 0;
   int          n_data_bytes = 0;
   logic        stalled = 1'b0;
   logic [7:0]  held_byte = '0;
   logic [15:0] last_addr = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Monitor: byte scoreboard, stall stability and RAM address log
   always @(negedge clk) begin
      if (rst) begin
         stalled = 1'b0;
      end else begin
         if (bvalid) begin
            if (stalled) check("stall_hold", 32'(bout), 32'(held_byte));
            if (bready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_byte: got %02h required no byte", bout);
               end else begin
                  check("byte", 32'(bout), 32'(exp_q.pop_front()));
               end
               bytes_seen++;
               stalled = 1'b0;
            end else begin
               stalled   = 1'b1;
               held_byte = bout;
            end
         end else begin
            stalled = 1'b0;
         end
         if (busy && addr !== last_addr) begin
            addr_log.push_back(addr);
            last_addr = addr;
         end
      end
   end

   // Ready generator: tied high, 5-cycle stall on each high byte, or random
   always @(negedge clk) begin
      if (!rst) begin
         if (bvalid && bready) begin
            rd_idx++;
            stall_cnt = 0;
         end else if (bvalid) begin
            stall_cnt++;
         end
      end
   end

   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0:       bready = 1'b1;
         1:       bready = !(bvalid && rd_idx < n_data_bytes && (rd_idx % 2) == 0 && stall_cnt < 5);
         default: bready = ($urandom_range(0, 2) != 0);
      endcase
   end

   // Reference model: byte stream and address list from matrix contents
   task automatic load_expect(input logic [15:0] b, input logic [7:0] r, input logic [7:0] c);
      int          n;
      logic [15:0] a;
      logic [15:0] w;
      logic [7:0]  cs;
      n  = int'(r) * int'(c);
      cs = 8'h00;
      exp_q.delete();
      exp_addr.delete();
      addr_log.delete();
      for (int i = 0; i < n; i++) begin
         a = 16'(int'(b) + i);
         w = mem[a];
         exp_addr.push_back(a);
         exp_q.push_back(w[15:8]);
         exp_q.push_back(w[7:0]);
         cs = cs ^ w[15:8] ^ w[7:0];
      end
`ifdef DUMP_CHECKSUM_EN
      exp_q.push_back(cs);
`endif
      n_data_bytes = 2 * n;
      exp_bytes    = exp_q.size();
      base = b; rows = r; cols = c;
      rd_idx = 0; stall_cnt = 0; bytes_seen = 0;
      last_addr = addr;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_done"}, 32'(done), 32'd1);
      check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
      check({name, "_byte_count"}, 32'(bytes_seen), 32'(exp_bytes));
      check({name, "_busy_in_done"}, 32'(busy), 32'd0);
   endtask

   task automatic end_dump(input string name);
      @(negedge clk) pd = 1'b0;
      @(posedge clk); #1;
      check({name, "_idle_done"}, 32'(done), 32'd0);
   endtask

   task automatic check_addrs(input string name);
      check({name, "_addr_count"}, 32'(addr_log.size()), 32'(exp_addr.size()));
      for (int i = 0; i < addr_log.size() && i < exp_addr.size(); i++)
         check({name, "_addr"}, 32'(addr_log[i]), 32'(exp_addr[i]));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] lit [9];
      int         lat;
      int         n;
      lit = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'h00, 8'hBE};
      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);

      // Reset state
      #1;
      check("rst_valid", 32'(bvalid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_addr", 32'(addr), 32'd0);
      check("rst_byte", 32'(bout), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      repeat (2) @(posedge clk);

      // 2x2 matrix at 0x0100, ready high, with start latency
      mem[16'h0100] = 16'h1234; mem[16'h0101] = 16'hABCD;
      mem[16'h0102] = 16'h0001; mem[16'h0103] = 16'hFF00;
      ready_mode = 0;
      load_expect(16'h0100, 8'd2, 8'd2);
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(lit[i]);
`ifdef DUMP_CHECKSUM_EN
      exp_q.push_back(lit[8]);
`endif
      exp_bytes = exp_q.size();
      @(negedge clk) pd = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      while (!bvalid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("first_valid_latency", 32'(lat), 32'd3);
      wait_done("basic");
      check_addrs("basic");
      end_dump("basic");

      // Same run with 5-cycle stalls on each high byte
      ready_mode = 1;
      load_expect(16'h0100, 8'd2, 8'd2);
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(lit[i]);
`ifdef DUMP_CHECKSUM_EN
      exp_q.push_back(lit[8]);
`endif
      exp_bytes = exp_q.size();
      @(negedge clk) pd = 1'b1;
      wait_done("stall");
      end_dump("stall");

      // Address wrap past 0xFFFF
      ready_mode = 0;
      load_expect(16'hFFFF, 8'd1, 8'd2);
      @(negedge clk) pd = 1'b1;
      wait_done("wrap");
      check_addrs("wrap");
      end_dump("wrap");

      // Zero-word dump
      load_expect(16'h0200, 8'd0, 8'd5);
      @(negedge clk) pd = 1'b1;
      @(posedge clk); #1;
      n = 0;
      while (!done && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      check("zero_done_within_2", 32'(n <= 2), 32'd1);
      wait_done("zero");
      check("zero_no_addr", 32'(addr_log.size()), 32'd0);
      end_dump("zero");

      // Reset after 3 bytes, no restart while level high, restart on new edge
      load_expect(16'h3000, 8'd3, 8'd3);
      @(negedge clk) pd = 1'b1;
      n = 0;
      while (bytes_seen < 3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("rst_mid_reached", 32'(bytes_seen), 32'd3);
      @(posedge clk); #2;
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("rst_mid_valid", 32'(bvalid), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_addr", 32'(addr), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("rst_no_resume_busy", 32'(busy), 32'd0);
      check("rst_no_resume_done", 32'(done), 32'd0);
      @(negedge clk) pd = 1'b0;
      repeat (2) @(posedge clk);
      load_expect(16'h3000, 8'd3, 8'd3);
      @(negedge clk) pd = 1'b1;
      wait_done("restart");
      end_dump("restart");

      // PROCESS_DONE toggled while busy is ignored
      load_expect(16'h4000, 8'd2, 8'd3);
      @(negedge clk) pd = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk) pd = 1'b0;
      @(negedge clk) pd = 1'b1;
      @(negedge clk) pd = 1'b0;
      @(negedge clk) pd = 1'b1;
      wait_done("toggle");
      repeat (5) @(posedge clk);
      #1;
      check("toggle_no_restart_busy", 32'(busy), 32'd0);
      check("toggle_count_unchanged", 32'(bytes_seen), 32'(exp_bytes));
      end_dump("toggle");

      // Randomized matrices with random ready
      ready_mode = 2;
      for (int t = 0; t < 5; t++) begin
         load_expect(16'($urandom), 8'($urandom_range(1, 4)), 8'($urandom_range(1, 4)));
         @(negedge clk) pd = 1'b1;
         wait_done("random");
         check_addrs("random");
         end_dump("random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
